// File: rtl/accel_bcd_convert.sv
// accel_bcd_convert: 12-bit two's-complement to sign + 4-digit BCD via double dabble,
// plus a free-running digit scan index for a multiplexed display.
module accel_bcd_convert #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] sample,
   input  logic        sample_valid,
   output logic        ready,
   output logic        done,
   output logic        sign,
   output logic [3:0]  thousands,
   output logic [3:0]  hundreds,
   output logic [3:0]  tens,
   output logic [3:0]  ones,
   output logic [1:0]  digit_sel
);
   localparam int PW = $clog2(REFRESH_DIV);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t         state;
   logic [11:0]    raw;
   logic [11:0]    mag;
   logic [15:0]    scratch;
   logic [15:0]    adj;
   logic [3:0]     bit_cnt;
   logic           neg;
   logic [PW-1:0]  pre;
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 4; i++)
         if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready     <= 1'b1;
         done      <= 1'b0;
         raw       <= '0;
         mag       <= '0;
         scratch   <= '0;
         bit_cnt   <= '0;
         neg       <= 1'b0;
         sign      <= 1'b0;
         thousands <= '0;
         hundreds  <= '0;
         tens      <= '0;
         ones      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (sample_valid) begin
               raw   <= sample;
               ready <= 1'b0;
               state <= LOAD;
            end
            LOAD: begin
               neg     <= raw[11];
               mag     <= raw[11] ? ~raw + 12'd1 : raw;
               scratch <= '0;
               bit_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: begin
               {scratch, mag} <= {adj, mag} << 1;
               bit_cnt        <= bit_cnt + 4'd1;
               if (bit_cnt == 4'd11) state <= DONE;
            end
            DONE: begin
               {thousands, hundreds, tens, ones} <= scratch;
               sign  <= neg;
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Scan runs regardless of converter activity.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre       <= '0;
         digit_sel <= '0;
      end else begin
         pre <= (pre == PW'(REFRESH_DIV - 1)) ? '0 : pre + 1'b1;
         if (pre == PW'(REFRESH_DIV - 1)) digit_sel <= digit_sel + 2'd1;
      end
   end
endmodule

// File: tb/tb_accel_bcd_convert.sv
// tb_accel_bcd_convert: randomized and directed checks against an arithmetic BCD model.
module tb_accel_bcd_convert;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] sample = '0;
   logic        sample_valid = 1'b0;
   logic        ready, done, sign;
   logic [3:0]  thousands, hundreds, tens, ones;
   logic [1:0]  digit_sel;
   logic [16:0] outs;
   int          checks = 0;
   int          errors = 0;
   assign outs = {sign, thousands, hundreds, tens, ones};
   always #5 clk = ~clk;
   accel_bcd_convert #(.REFRESH_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .sample(sample), .sample_valid(sample_valid),
      .ready(ready), .done(done), .sign(sign), .thousands(thousands),
      .hundreds(hundreds), .tens(tens), .ones(ones), .digit_sel(digit_sel)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [16:0] ref_bcd(input logic [11:0] s);
      int v;
      v = s[11] ? 4096 - int'(s) : int'(s);
      return {(s[11] && v != 0), 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   task automatic convert(input logic [11:0] v, input int intf_at, input logic [11:0] intf_v);
      logic [16:0] prev;
      int n, lows, changes, w;
      w = 0;
      while (!ready && w < 40) begin
         @(posedge clk); #1; w++;
      end
      check("ready_wait", ready, 1);
      prev = outs;
      sample = v;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      check("done_width", done, 0);
      n = 0; lows = 0; changes = 0;
      while (!done && n < 40) begin
         sample_valid = 1'b0;
         if (!ready) lows++;
         if (outs !== prev) changes++;
         n++;
         if (n == intf_at - 1) begin
            sample = intf_v;
            sample_valid = 1'b1;
         end
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      check("latency", n, 14);
      check("ready_low", lows, 14);
      check("outs_stable", changes, 0);
      check($sformatf("result_%03h", v), outs, ref_bcd(v));
      check("ready_back", ready, 1);
   endtask
   initial begin
      int dones, bad;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_outs", outs, 0);
      check("rst_sel", digit_sel, 0);
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         sample_valid = 1'b0;
         if (k == 3) begin
            sample = 12'h555;
            sample_valid = 1'b1;
         end
         @(posedge clk); #1;
         check($sformatf("scan_%0d", k), digit_sel, (k / 4) % 4);
      end
      sample_valid = 1'b0;
      convert(12'h7FF, 0, 12'h0);
      convert(12'h800, 0, 12'h0);
      convert(12'hF85, 0, 12'h0);
      convert(12'h000, 0, 12'h0);
      convert(12'h00C, 5, 12'h7FF);
      convert(12'h001, 14, 12'h555);
      @(posedge clk); #1;
      check("done_edge_ignored", ready, 1);
      convert(12'h00C, 0, 12'h0);
      sample = 12'h123;
      sample_valid = 1'b1;
      @(posedge clk); #1;
      sample_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort_outs", outs, 0);
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      check("abort_sel", digit_sel, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      dones = 0; bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (done) dones++;
         if (outs !== 17'h0) bad++;
      end
      check("abort_no_done", dones, 0);
      check("abort_outs_hold", bad, 0);
      convert(12'h0FF, 0, 12'h0);
      for (int i = 0; i < 16; i++) convert(12'($urandom_range(0, 4095)), 0, 12'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/accel_bcd_convert.md
ACCEL_BCD_CONVERT -- requirements
Module: accel_bcd_convert

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit_sel advance (1 kHz digit scan at 100 MHz); legal range is 2 and up.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sample, input, 12 bits: two's-complement accelerometer axis reading.
REQ-005 The block SHALL have port sample_valid, input, 1 bit: single-cycle strobe qualifying sample.
REQ-006 The block SHALL have port ready, output, 1 bit: high when the converter is idle and can accept a sample.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a new digit set on the outputs.
REQ-008 The block SHALL have port sign, output, 1 bit: 1 when the displayed value is negative.
REQ-009 The block SHALL have ports thousands, hundreds, tens and ones, each an output of 4 bits: BCD digits of the magnitude.
REQ-010 The block SHALL have port digit_sel, output, 2 bits: display scan index 0..3, feeding the downstream display stage's digit select.

Function
REQ-011 The converter FSM SHALL have the states IDLE, LOAD, SHIFT and DONE; ready SHALL be 1 only in IDLE.
REQ-012 In IDLE, sample_valid=1 SHALL capture sample into an internal register and move the FSM to LOAD; otherwise the FSM SHALL stay in IDLE.
REQ-013 In LOAD, the block SHALL latch the sign bit (sample[11]), compute the 12-bit unsigned magnitude (negated when negative; 0x800 gives 2048 with no overflow), clear the 16-bit BCD scratch register, clear the bit counter, and move the FSM to SHIFT.
REQ-014 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to each scratch nibble that is 5 or more, then shift {scratch, magnitude} left by 1 bit.
REQ-015 After exactly 12 SHIFT cycles the FSM SHALL move to DONE.
REQ-016 In DONE, the block SHALL copy scratch[15:12], [11:8], [7:4] and [3:0] to thousands, hundreds, tens and ones, copy the latched sign to sign, assert done for that cycle only, and return the FSM to IDLE.
REQ-017 Latency from the accepting clock edge to the edge that updates the outputs SHALL be 14 cycles; throughput SHALL be one sample per 15 cycles.
REQ-018 The digit and sign outputs SHALL be double-buffered: they SHALL change only on the DONE edge and never show intermediate scratch values.
REQ-019 A zero magnitude SHALL always produce sign=0, including negative-zero encodings, which cannot occur in 12-bit two's complement.
REQ-020 sample_valid while ready=0 SHALL be ignored: the sample SHALL be dropped and the in-flight conversion SHALL continue undisturbed.
REQ-021 sample_valid arriving in the same cycle as the DONE-to-IDLE transition SHALL be ignored; acceptance SHALL require the FSM to already be in IDLE.
REQ-022 A free-running prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0.
REQ-023 On each prescaler wrap, digit_sel SHALL increment modulo 4 (3 wraps to 0).
REQ-024 The scan logic SHALL be independent of the converter FSM state.

Reset
REQ-025 While rst_n=0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-026 While rst_n=0, ready SHALL be 1 and done SHALL be 0.
REQ-027 While rst_n=0, sign, thousands, hundreds, tens, ones, digit_sel, the prescaler, the scratch register and the bit counter SHALL all be 0.
REQ-028 Reset asserted mid-conversion SHALL abort the conversion with no done pulse and outputs at 0; the first sample_valid after rst_n rises SHALL be accepted normally.

Verification
REQ-029 The bench SHALL cover: sample=0x7FF, valid for 1 cycle -> done exactly 14 edges later; sign=0, digits 2,0,4,7; ready low for 14 cycles.
REQ-030 The bench SHALL cover: sample=0x800 -> sign=1, digits 2,0,4,8; sample=0xF85 -> sign=1, digits 0,1,2,3; sample=0x000 -> sign=0, digits 0,0,0,0.
REQ-031 The bench SHALL cover: 0x00C accepted, then 0x7FF pulsed 5 cycles later -> a single done with 0,0,1,2; outputs stay unchanged until that done edge.
REQ-032 The bench SHALL cover: REFRESH_DIV=4, run 20 cycles from reset -> digit_sel sequence 0,1,2,3,0 advancing every 4th edge, unaffected by concurrent conversions.
REQ-033 The bench SHALL cover: rst_n pulsed low 6 cycles into a conversion of 0x123 -> no done pulse, outputs 0, ready=1; a new 0x0FF after release -> 0,2,5,5.
REQ-034 The bench SHALL cover: back-to-back samples, each issued on the cycle after ready returns to 1, over 16 random values -> every value converted, matching a reference model.
